// File: rtl/stack_controller.sv
// Sequencer for a full-descending hardware stack: turns PUSH/POP requests into
// SP register and memory control steps, tracks depth and flags overflow/underflow.
module stack_controller #(
   parameter logic [15:0] BASE      = 16'h0000,
   parameter int          MAX_DEPTH = 16,
   parameter int          DEPTH_W   = 5
) (
   input  logic               CLK,
   input  logic               RESETN,
   input  logic               PUSH,
   input  logic               POP,
   input  logic               MEM_RDY,
   output logic               SP_LDN,
   output logic               SP_IDN,
   output logic               SP_INC_DECN,
   output logic               SP_OEN,
   output logic [15:0]        SP_DIN,
   output logic               MEM_REQ,
   output logic               MEM_WE,
   output logic               BUSY,
   output logic               DONE,
   output logic               ERR_OVF,
   output logic               ERR_UNF,
   output logic [DEPTH_W-1:0] DEPTH
);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_DEC,
      S_WR,
      S_RD,
      S_INC,
      S_FIN
   } state_t;

   localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(MAX_DEPTH);

   state_t             state_reg, state_next;
   logic [DEPTH_W-1:0] depth_reg, depth_next;
   logic               ovf_reg, ovf_next;
   logic               unf_reg, unf_next;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_reg <= S_INIT;
         depth_reg <= '0;
         ovf_reg   <= 1'b0;
         unf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         depth_reg <= depth_next;
         ovf_reg   <= ovf_next;
         unf_reg   <= unf_next;
      end
   end

   // Every control output is a decode of the state register, so nothing on
   // the bus side ever follows PUSH/POP/MEM_RDY combinationally.
   always_comb begin
      state_next  = state_reg;
      depth_next  = depth_reg;
      ovf_next    = 1'b0;
      unf_next    = 1'b0;
      SP_LDN      = 1'b1;
      SP_IDN      = 1'b1;
      SP_INC_DECN = 1'b1;
      SP_OEN      = 1'b1;
      MEM_REQ     = 1'b0;
      MEM_WE      = 1'b0;
      BUSY        = 1'b1;
      DONE        = 1'b0;

      case (state_reg)
         S_INIT: begin
            SP_LDN     = 1'b0;
            state_next = S_IDLE;
         end
         S_IDLE: begin
            BUSY = 1'b0;
            if (PUSH) begin
               if (depth_reg < FULL) state_next = S_DEC;
               else                  ovf_next   = 1'b1;
            end else if (POP) begin
               if (depth_reg != '0) state_next = S_RD;
               else                 unf_next   = 1'b1;
            end
         end
         S_DEC: begin
            SP_IDN      = 1'b0;
            SP_INC_DECN = 1'b0;
            state_next  = S_WR;
         end
         S_WR: begin
            SP_OEN  = 1'b0;
            MEM_REQ = 1'b1;
            MEM_WE  = 1'b1;
            if (MEM_RDY) begin
               state_next = S_FIN;
               depth_next = depth_reg + 1'b1;
            end
         end
         S_RD: begin
            SP_OEN  = 1'b0;
            MEM_REQ = 1'b1;
            if (MEM_RDY) state_next = S_INC;
         end
         S_INC: begin
            SP_IDN     = 1'b0;
            state_next = S_FIN;
            depth_next = depth_reg - 1'b1;
         end
         S_FIN: begin
            DONE       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_INIT;
      endcase
   end

   assign SP_DIN  = BASE;
   assign ERR_OVF = ovf_reg;
   assign ERR_UNF = unf_reg;
   assign DEPTH   = depth_reg;

endmodule

// File: tb/tb_stack_controller.sv
// Bench for stack_controller: directed push/pop sequences with a scoreboard of
// expected memory accesses, completions and error pulses, plus an SP register model.
module tb_stack_controller;
   localparam logic [15:0] BASE = 16'h0100;

   logic        CLK = 1'b0;
   logic        RESETN = 1'b1;
   logic        PUSH = 1'b0;
   logic        POP = 1'b0;
   logic        MEM_RDY = 1'b1;
   logic        SP_LDN, SP_IDN, SP_INC_DECN, SP_OEN, MEM_REQ, MEM_WE;
   logic        BUSY, DONE, ERR_OVF, ERR_UNF;
   logic [15:0] SP_DIN;
   logic [4:0]  DEPTH;

   always #5 CLK = ~CLK;

   stack_controller #(.BASE(BASE), .MAX_DEPTH(16), .DEPTH_W(5)) dut (
      .CLK(CLK), .RESETN(RESETN), .PUSH(PUSH), .POP(POP), .MEM_RDY(MEM_RDY),
      .SP_LDN(SP_LDN), .SP_IDN(SP_IDN), .SP_INC_DECN(SP_INC_DECN), .SP_OEN(SP_OEN),
      .SP_DIN(SP_DIN), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .BUSY(BUSY), .DONE(DONE),
      .ERR_OVF(ERR_OVF), .ERR_UNF(ERR_UNF), .DEPTH(DEPTH)
   );

   // External 16-bit SP register as driven by the controller
   logic [15:0] sp_model;
   always @(posedge CLK) begin
      if (!SP_LDN)      sp_model <= SP_DIN;
      else if (!SP_IDN) sp_model <= SP_INC_DECN ? sp_model + 16'd2 : sp_model - 16'd2;
   end

   typedef enum int {EV_MEM, EV_DONE, EV_OVF, EV_UNF} ev_kind_t;
   typedef struct {
      ev_kind_t    kind;
      logic [15:0] addr;
      logic        we;
      logic [4:0]  depth;
   } ev_t;

   ev_t         exp_q[$];
   int          tests = 0;
   int          fails = 0;
   int          exp_depth = 0;
   logic [15:0] exp_sp = BASE;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic expect_ev(input ev_kind_t k, input logic [15:0] a, input logic w, input int d);
      ev_t e;
      e.kind  = k;
      e.addr  = a;
      e.we    = w;
      e.depth = 5'(d);
      exp_q.push_back(e);
   endtask

   task automatic mon(input ev_kind_t k);
      ev_t e;
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL unexpected_event: got kind %0d, expected none", k);
         return;
      end
      e = exp_q.pop_front();
      check("event_kind", k, e.kind);
      if (k == EV_MEM) begin
         check("mem_addr", sp_model, e.addr);
         check("mem_we", MEM_WE, e.we);
      end else begin
         check("event_depth", DEPTH, e.depth);
      end
      $display("[TB] event kind=%0d depth=%0d sp=%04h", k, DEPTH, sp_model);
   endtask

   // Monitor: samples on the falling edge, independent of the stimulus
   initial begin
      forever begin
         @(negedge CLK);
         if (RESETN) begin
            check("oen_with_req", MEM_REQ, !SP_OEN);
            if (MEM_REQ && MEM_RDY) mon(EV_MEM);
            if (DONE)               mon(EV_DONE);
            if (ERR_OVF)            mon(EV_OVF);
            if (ERR_UNF)            mon(EV_UNF);
         end
      end
   end

   // One request at an edge; returns cycles until BUSY falls and MEM_REQ cycles seen
   task automatic op(input logic p, input logic q, input int stall, input logic pester,
                     output int lat, output int reqc);
      int k;
      MEM_RDY = (stall == 0);
      PUSH = p;
      POP  = q;
      @(posedge CLK); #1;
      PUSH = pester;
      POP  = 1'b0;
      k = 0;
      reqc = 0;
      while (BUSY === 1'b1 && k < 50) begin
         if (MEM_REQ) reqc++;
         if (stall > 0 && k == stall + 1) MEM_RDY = 1'b1;
         @(posedge CLK); #1;
         k++;
      end
      if (k >= 50) begin
         tests++;
         fails++;
         $display("FAIL op_timeout: got %0d cycles busy, expected fewer than 50", k);
      end
      PUSH = 1'b0;
      MEM_RDY = 1'b1;
      lat = k;
   endtask

   task automatic do_push(input logic with_pop, input int stall, output int lat, output int reqc);
      if (exp_depth < 16) begin
         exp_sp = exp_sp - 16'd2;
         exp_depth++;
         expect_ev(EV_MEM, exp_sp, 1'b1, 0);
         expect_ev(EV_DONE, 16'h0, 1'b0, exp_depth);
      end else begin
         expect_ev(EV_OVF, 16'h0, 1'b0, exp_depth);
      end
      op(1'b1, with_pop, stall, 1'b0, lat, reqc);
   endtask

   task automatic do_pop(input logic pester, output int lat);
      int rc;
      if (exp_depth > 0) begin
         expect_ev(EV_MEM, exp_sp, 1'b0, 0);
         exp_sp = exp_sp + 16'd2;
         exp_depth--;
         expect_ev(EV_DONE, 16'h0, 1'b0, exp_depth);
      end else begin
         expect_ev(EV_UNF, 16'h0, 1'b0, exp_depth);
      end
      op(1'b0, 1'b1, 0, pester, lat, rc);
   endtask

   initial begin
      int lat, rc;
      // Reset and base load
      #2 RESETN = 1'b0;
      @(posedge CLK); @(posedge CLK); #1;
      check("rst_busy", BUSY, 1);
      check("rst_ldn", SP_LDN, 0);
      check("rst_depth", DEPTH, 0);
      check("rst_memreq", MEM_REQ, 0);
      check("rst_flags", {DONE, ERR_OVF, ERR_UNF, SP_IDN, SP_OEN, SP_INC_DECN}, 6'b000111);
      #2 RESETN = 1'b1;
      #1 check("init_ldn", SP_LDN, 0);
      @(posedge CLK); #1;
      check("idle_ldn", SP_LDN, 1);
      check("idle_busy", BUSY, 0);
      check("idle_depth", DEPTH, 0);
      check("idle_sp", sp_model, BASE);
      $display("[TB] reset done sp=%04h", sp_model);

      // Single push then pop
      do_push(1'b0, 0, lat, rc);
      check("push_latency", lat, 3);
      check("push_req_cycles", rc, 1);
      check("push_depth", DEPTH, 1);
      do_pop(1'b0, lat);
      check("pop_latency", lat, 3);
      check("pop_depth", DEPTH, 0);
      check("pop_sp", sp_model, BASE);

      // Push with four not-ready cycles
      do_push(1'b0, 4, lat, rc);
      check("stall_latency", lat, 7);
      check("stall_req_cycles", rc, 5);
      check("stall_depth", DEPTH, 1);

      // Fill to the limit, then overflow
      for (int i = 0; i < 15; i++) do_push(1'b0, 0, lat, rc);
      check("full_depth", DEPTH, 16);
      check("full_sp", sp_model, BASE - 16'd32);
      do_push(1'b0, 0, lat, rc);
      check("ovf_latency", lat, 0);
      check("ovf_req_cycles", rc, 0);
      @(posedge CLK); #1;
      check("ovf_pulse_end", ERR_OVF, 0);
      check("ovf_depth", DEPTH, 16);
      check("ovf_busy", BUSY, 0);

      // Drain, then underflow
      for (int i = 0; i < 16; i++) do_pop(1'b0, lat);
      check("empty_depth", DEPTH, 0);
      check("empty_sp", sp_model, BASE);
      do_pop(1'b0, lat);
      check("unf_latency", lat, 0);
      @(posedge CLK); #1;
      check("unf_pulse_end", ERR_UNF, 0);
      check("unf_sp", sp_model, BASE);

      // Push wins over pop; requests during BUSY are dropped
      do_push(1'b0, 0, lat, rc);
      do_push(1'b0, 0, lat, rc);
      do_push(1'b1, 0, lat, rc);
      check("both_latency", lat, 3);
      check("both_depth", DEPTH, 3);
      check("both_sp", sp_model, BASE - 16'd6);
      do_pop(1'b1, lat);
      check("pester_latency", lat, 3);
      @(posedge CLK); #1;
      check("pester_busy", BUSY, 0);
      check("pester_depth", DEPTH, 2);

      // Reset while waiting in WR
      MEM_RDY = 1'b0;
      PUSH = 1'b1;
      @(posedge CLK); #1;
      PUSH = 1'b0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      check("wr_wait_req", MEM_REQ, 1);
      #2 RESETN = 1'b0;
      #1;
      check("abort_memreq", MEM_REQ, 0);
      check("abort_depth", DEPTH, 0);
      check("abort_ldn", SP_LDN, 0);
      exp_depth = 0;
      exp_sp = BASE;
      MEM_RDY = 1'b1;
      @(posedge CLK); #1;
      RESETN = 1'b1;
      @(posedge CLK); #1;
      check("reinit_ldn", SP_LDN, 1);
      check("reinit_busy", BUSY, 0);
      check("reinit_sp", sp_model, BASE);
      @(posedge CLK); #1;
      check("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/stack_controller.md
# stack_controller

Sequencer for a hardware stack built from one 16-bit `register` instance used as stack pointer (SP) plus an external data memory. It turns single-cycle PUSH/POP requests into the ordered register and memory control sequence for a full-descending stack (pre-decrement on push, post-increment on pop, step of 2 bytes). It tracks stack depth, flags overflow and underflow, and loads the SP base after reset. It sits between the instruction decoder and the SP register and memory bus.

## Interface
- BASE, 16'h0000: value loaded into SP after reset (address one word above the stack top).
- MAX_DEPTH, 16: maximum number of stacked words.
- DEPTH_W, 5: width of DEPTH; must satisfy 2^DEPTH_W > MAX_DEPTH.

- CLK  in  1  clock, rising edge.
- RESETN  in  1  reset; one clock; reset is asynchronous and active-low.
- PUSH  in  1  push request, sampled only in IDLE.
- POP  in  1  pop request, sampled only in IDLE.
- MEM_RDY  in  1  memory completes the current access on a rising edge where MEM_RDY=1 and MEM_REQ=1.
- SP_LDN  out  1  to SP register LDN (active-low load).
- SP_IDN  out  1  to SP register IDN (active-low inc/dec enable).
- SP_INC_DECN  out  1  to SP register INC_DECN (1=+2, 0=-2).
- SP_OEN  out  1  to SP register address-bus OEN (active-low drive).
- SP_DIN  out  16  constant BASE, to SP register DIN.
- MEM_REQ  out  1  memory access request.
- MEM_WE  out  1  1=write (push), 0=read (pop); valid while MEM_REQ=1.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse on completion of an accepted push or pop.
- ERR_OVF  out  1  one-cycle pulse: push rejected, stack full.
- ERR_UNF  out  1  one-cycle pulse: pop rejected, stack empty.
- DEPTH  out  DEPTH_W  current number of stacked words.

## Operation
- States: INIT, IDLE, DEC, WR, RD, INC, FIN. All outputs registered or pure state decode; no combinational path from inputs to outputs.
- Reset (RESETN=0, asynchronous): state=INIT, DEPTH=0, DONE=ERR_OVF=ERR_UNF=0, MEM_REQ=0, MEM_WE=0, SP_IDN=1, SP_INC_DECN=1, SP_OEN=1, SP_LDN=0, BUSY=1.
- INIT: SP_LDN=0 (loads BASE); then IDLE unconditionally on the next edge.
- IDLE: all active-low controls high, MEM_REQ=0. On an edge:
  - PUSH=1 and DEPTH<MAX_DEPTH -> DEC.
  - PUSH=1 and DEPTH==MAX_DEPTH -> stay IDLE, ERR_OVF=1 next cycle.
  - PUSH=0, POP=1, DEPTH>0 -> RD.
  - PUSH=0, POP=1, DEPTH==0 -> stay IDLE, ERR_UNF=1 next cycle.
  - PUSH and POP both high: PUSH wins; POP is dropped.
- DEC: SP_IDN=0, SP_INC_DECN=0 for exactly one cycle -> WR.
- WR: SP_OEN=0, MEM_REQ=1, MEM_WE=1; hold until MEM_RDY=1 -> FIN, DEPTH+1.
- RD: SP_OEN=0, MEM_REQ=1, MEM_WE=0; hold until MEM_RDY=1 -> INC.
- INC: SP_IDN=0, SP_INC_DECN=1 for exactly one cycle -> FIN, DEPTH-1.
- FIN: DONE=1 for one cycle -> IDLE.
- Requests outside IDLE are ignored, not queued. SP_LDN is 0 only in INIT. SP_OEN and MEM_REQ are asserted together.

## Timing
- Push with MEM_RDY=1: request edge E; DEC in E..E+1, WR in E+1..E+2, DONE high E+2..E+3; BUSY high 3 cycles; next request accepted at E+4.
- Pop with MEM_RDY=1: RD in E..E+1, INC in E+1..E+2, DONE high E+2..E+3.
- Each MEM_RDY=0 cycle in WR or RD adds one cycle.
- DEPTH updates on the edge entering FIN. Error flags are high for the cycle after the rejecting edge.
- Reset mid-operation: abort immediately; MEM_REQ drops asynchronously; DEPTH=0; INIT reloads BASE.

## Test plan
- Reset with BASE=16'h0100, release -> SP_LDN=0 for one cycle, then IDLE, BUSY=0, DEPTH=0, SP=16'h0100.
- PUSH with MEM_RDY=1 -> one DEC cycle, one write at SP=16'h00FE, DONE 3 cycles after request, DEPTH=1; then POP -> read at 16'h00FE, SP=16'h0100, DEPTH=0.
- PUSH with MEM_RDY low for 4 cycles -> MEM_REQ/MEM_WE/SP_OEN held for 5 cycles, DONE 7 cycles after request.
- 16 pushes, then a 17th -> ERR_OVF one-cycle pulse, no memory access, DEPTH=16; POP at DEPTH=0 -> ERR_UNF, SP unchanged.
- PUSH and POP high together at DEPTH=2 -> push only, DEPTH=3; PUSH pulsed during BUSY -> ignored.
- RESETN low during WR wait -> MEM_REQ=0 immediately, DEPTH=0, and INIT reload follows release.
